// File: rtl/mem_if_pkg.sv
// Shared definitions for the mem_if layer: access-size codes, arbiter state
// encoding and a one-hot helper.
package mem_if_pkg;

  localparam logic [1:0] MEM_ACC_8  = 2'd0;
  localparam logic [1:0] MEM_ACC_16 = 2'd1;
  localparam logic [1:0] MEM_ACC_32 = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_GAP    = 2'd2
  } arb_state_t;

  // Callers truncate the result to their own client count.
  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after the last
// holder, wrapping around, so the last holder itself has lowest priority.
module rr_picker #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    requests,
  input  logic [IDXW-1:0] last_holder,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_holder) + k) % N;
      if (!valid && requests[idx]) begin
        winner = IDXW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-client memory-bus arbiter: round-robin with burst-hold budget, or
// highest-index fixed priority when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arbiter_rr
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CLIENT_CNT = 4,
  parameter int MAX_HOLD   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CLIENT_CNT-1:0]            client_requests,
  input  logic [CLIENT_CNT*ADDR_WIDTH-1:0] client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]            client_wes,
  input  logic [2*CLIENT_CNT-1:0]          client_data_widths_packed,
  input  logic [CLIENT_CNT*DATA_WIDTH-1:0] client_data_outs_packed,
  output logic [CLIENT_CNT*DATA_WIDTH-1:0] client_data_ins_packed,
  output logic [CLIENT_CNT-1:0]            client_readies,
  output logic [CLIENT_CNT-1:0]            client_grants,
  input  logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic                             mem_ready,
  output logic                             mem_request,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data_out,
  output logic [1:0]                       mem_data_width,
  output logic                             mem_we_out
);

  localparam int IDX_W = $clog2(CLIENT_CNT);

  arb_state_t            state_q;
  logic [IDX_W-1:0]      holder_q;
  logic [CLIENT_CNT-1:0] grants_q;
  logic [IDX_W-1:0]      win_idx;
  logic                  any_req;

  assign any_req = |client_requests;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Legacy ordering: the highest-index requester always wins.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < CLIENT_CNT; i++) begin
      if (client_requests[i]) win_idx = IDX_W'(i);
    end
  end
`else
  localparam int HC_W = $clog2(MAX_HOLD + 1) + 1;

  logic [HC_W-1:0]  hold_cnt_q;
  logic [HC_W-1:0]  hold_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             others_req;
  logic             keep;

  rr_picker #(.N(CLIENT_CNT), .IDXW(IDX_W)) u_picker (
    .requests    (client_requests),
    .last_holder (holder_q),
    .winner      (pick_idx),
    .valid       (pick_valid)
  );

  // The holder keeps the bus while within budget, or whenever it is uncontested.
  always_comb begin
    others_req = |(client_requests & ~CLIENT_CNT'(onehot(int'(holder_q))));
    keep = client_requests[holder_q] &&
           ((MAX_HOLD == 0) || (int'(hold_cnt_q) < MAX_HOLD) || !others_req);
    win_idx   = holder_q;
    hold_next = HC_W'(1);
    if (keep) begin
      if (int'(hold_cnt_q) < MAX_HOLD) hold_next = hold_cnt_q + HC_W'(1);
      else                             hold_next = hold_cnt_q;
    end else if (pick_valid) begin
      win_idx = pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (state_q == ARB_IDLE && any_req) begin
      hold_cnt_q <= hold_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      holder_q <= IDX_W'(CLIENT_CNT - 1);
      grants_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            holder_q <= win_idx;
            grants_q <= CLIENT_CNT'(onehot(int'(win_idx)));
            state_q  <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (mem_ready) state_q <= ARB_GAP;
        end
        ARB_GAP: begin
          grants_q <= '0;
          state_q  <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // IDLE forwards the freshly computed winner; ACCESS and GAP use the holder.
  logic [IDX_W-1:0] sel;
  logic             mux_en;

  always_comb begin
    sel    = (state_q == ARB_IDLE) ? win_idx : holder_q;
    mux_en = !rst && ((state_q != ARB_IDLE) || any_req);
    mem_request    = !rst && (((state_q == ARB_IDLE) && any_req) || (state_q == ARB_ACCESS));
    mem_addr       = '0;
    mem_data_out   = '0;
    mem_data_width = '0;
    mem_we_out     = 1'b0;
    if (mux_en) begin
      mem_addr       = client_addrs_packed[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_data_out   = client_data_outs_packed[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      mem_data_width = client_data_widths_packed[int'(sel)*2 +: 2];
      mem_we_out     = client_wes[sel];
    end
  end

  always_comb begin
    client_grants  = rst ? '0 : grants_q;
    client_readies = '0;
    if (!rst && state_q == ARB_ACCESS && mem_ready) begin
      client_readies = CLIENT_CNT'(onehot(int'(holder_q)));
    end
    client_data_ins_packed = '0;
    for (int i = 0; i < CLIENT_CNT; i++) begin
      if (client_grants[i]) client_data_ins_packed[i*DATA_WIDTH +: DATA_WIDTH] = mem_data_in;
    end
  end

endmodule
